// File: rtl/lisa_fetch_if.sv
// Bus bundle between the fetch stage, program memory and the decoder.
//
// Decoder handshake: out_valid/out_ready follow strict valid/ready rules.
// A transfer happens on a rising edge where out_valid && out_ready. Once
// out_valid is high, every field is held unchanged until that edge.
// out_valid is never withdrawn without a transfer, except by a redirect
// from execute.
// Memory side: mem_rd_en/mem_addr form a read command. mem_rdata returns
// the byte exactly one cycle after the command.
interface lisa_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        opcode;
    logic [7:0]        inst_len;
    logic [55:0]       inst_bytes;
    logic              len_valid;
    logic [ADDR_W-1:0] inst_pc;

    // The fetch stage drives the memory command and the instruction fields.
    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output opcode, inst_len, inst_bytes, len_valid, inst_pc
    );

    // The memory model and the decoder sit on the other side.
    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  opcode, inst_len, inst_bytes, len_valid, inst_pc
    );
endinterface

// File: rtl/lisa_fetch.sv
// lisa_fetch: instruction fetch/length stage ahead of lisa_decoder.
// The stage reads program memory one byte per cycle and assembles
// {opcode, len, payload}. It then hands the result to the decoder.
// Sequential fetch stops after control-flow, terminal or illegal-length
// instructions. It resumes on a redirect from execute.

`ifndef LLVM_OP_ADD
`define LLVM_OP_ADD  8'h01
`endif
`ifndef LLVM_OP_LOAD
`define LLVM_OP_LOAD 8'h10
`endif
`ifndef LLVM_OP_BR
`define LLVM_OP_BR   8'h20
`endif
`ifndef LLVM_OP_JMP
`define LLVM_OP_JMP  8'h21
`endif
`ifndef LLVM_OP_RET
`define LLVM_OP_RET  8'h22
`endif
`ifndef LLVM_OP_HALT
`define LLVM_OP_HALT 8'hFF
`endif

module lisa_fetch #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic [1:0]        state_dbg,
    lisa_fetch_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;        // address of the opcode byte being fetched
    logic [3:0]        cur_idx;   // byte index of the read currently on mem_addr
    logic              cap_vld;   // mem_rdata carries a byte of this instruction
    logic [3:0]        cap_idx;   // byte index carried on mem_rdata

    logic [7:0]        len_now;
    logic              len_ok;
    logic              cap_done;
    logic              cap_bad;
    logic [3:0]        nxt_idx;
    logic              more_rd;
    logic [2:0]        pay_sel;
    logic              hs;
    logic              seq_ok;
    logic              go_fetch;
    logic [ADDR_W-1:0] go_pc;

    // Control-flow and terminal opcodes end sequential fetch.
    function automatic logic is_ctrl(input logic [7:0] op);
        return (op == `LLVM_OP_BR) || (op == `LLVM_OP_JMP) ||
               (op == `LLVM_OP_RET) || (op == `LLVM_OP_HALT);
    endfunction

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Capture and read bookkeeping. The length byte is used straight off
    // the bus on the cycle it arrives, so the read decision is not delayed.
    always_comb begin
        len_now  = (cap_vld && cap_idx == 4'd1) ? bus.mem_rdata : bus.inst_len;
        len_ok   = (len_now >= 8'd2) && (len_now <= 8'(MAX_LEN));
        cap_bad  = cap_vld && (cap_idx == 4'd1) && !len_ok;
        cap_done = cap_vld && (cap_idx != 4'd0) && len_ok &&
                   (({4'b0, cap_idx} + 8'd1) == len_now);
        nxt_idx  = cur_idx + 4'd1;
        // Bytes 0..2 are read before the length is known. After that,
        // reads stop exactly at the end of the instruction.
        more_rd  = bus.mem_rd_en &&
                   ((nxt_idx <= 4'd2) || ({4'b0, nxt_idx} < len_now));
        pay_sel  = 3'(cap_idx - 4'd2);
    end

    // Entry into FETCH: start from IDLE, redirect from any active state,
    // or a sequential continue after an accepted instruction.
    always_comb begin
        hs       = bus.out_valid && bus.out_ready;
        seq_ok   = bus.len_valid && !is_ctrl(bus.opcode);
        go_fetch = 1'b0;
        go_pc    = pc;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    go_fetch = 1'b1;
                    go_pc    = start_pc;
                end
            end
            ST_OUT: begin
                if (redirect_valid) begin
                    go_fetch = 1'b1;
                    go_pc    = redirect_pc;
                end else if (hs && seq_ok) begin
                    go_fetch = 1'b1;
                    go_pc    = pc + ADDR_W'(bus.inst_len);
                end
            end
            default: begin
                if (redirect_valid) begin
                    go_fetch = 1'b1;
                    go_pc    = redirect_pc;
                end
            end
        endcase
    end

    // Fetch FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pc             <= '0;
            cur_idx        <= '0;
            cap_vld        <= 1'b0;
            cap_idx        <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.out_valid  <= 1'b0;
            bus.opcode     <= '0;
            bus.inst_len   <= '0;
            bus.inst_bytes <= '0;
            bus.len_valid  <= 1'b0;
            bus.inst_pc    <= '0;
        end else if (go_fetch) begin
            state          <= ST_FETCH;
            pc             <= go_pc;
            cur_idx        <= '0;
            cap_vld        <= 1'b0;
            cap_idx        <= '0;
            bus.mem_rd_en  <= 1'b1;
            bus.mem_addr   <= go_pc;
            bus.out_valid  <= 1'b0;
            bus.opcode     <= '0;
            bus.inst_len   <= '0;
            bus.inst_bytes <= '0;
            bus.len_valid  <= 1'b0;
            bus.inst_pc    <= go_pc;
        end else begin
            case (state)
                ST_FETCH: begin
                    cap_vld <= bus.mem_rd_en;
                    cap_idx <= cur_idx;
                    if (cap_vld) begin
                        case (cap_idx)
                            4'd0:    bus.opcode   <= bus.mem_rdata;
                            4'd1:    bus.inst_len <= bus.mem_rdata;
                            default: begin
                                if (cap_idx <= 4'd8)
                                    bus.inst_bytes[{pay_sel, 3'b000} +: 8] <= bus.mem_rdata;
                            end
                        endcase
                    end
                    if (cap_bad || cap_done) begin
                        state         <= ST_OUT;
                        bus.out_valid <= 1'b1;
                        bus.len_valid <= !cap_bad;
                        bus.mem_rd_en <= 1'b0;
                        cap_vld       <= 1'b0;
                    end else if (more_rd) begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= pc + ADDR_W'(nxt_idx);
                        cur_idx       <= nxt_idx;
                    end else begin
                        bus.mem_rd_en <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (hs) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                default: begin
                    // IDLE ignores redirects; WAIT holds until a redirect.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lisa_fetch.sv
// Directed testbench for lisa_fetch. A byte-wide memory model answers
// one cycle after each read. Every test task checks the DUT against
// hand-computed values.

`ifndef LLVM_OP_ADD
`define LLVM_OP_ADD  8'h01
`endif
`ifndef LLVM_OP_LOAD
`define LLVM_OP_LOAD 8'h10
`endif
`ifndef LLVM_OP_BR
`define LLVM_OP_BR   8'h20
`endif
`ifndef LLVM_OP_HALT
`define LLVM_OP_HALT 8'hFF
`endif

module tb_lisa_fetch;
    localparam int AW = 16;
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_OUT = 2'd2, S_WAIT = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          busy;
    logic [1:0]    state_dbg;

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] rd_log[$];
    int            n_checks = 0;
    int            n_fail = 0;

    lisa_fetch_if #(.ADDR_W(AW)) bus();

    lisa_fetch #(.ADDR_W(AW), .MAX_LEN(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .state_dbg(state_dbg), .bus(bus.master)
    );

    // clock
    always #5 clk = ~clk;

    // memory model: data one cycle after the read, reads logged
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_log.push_back(bus.mem_addr);
        end else begin
            bus.mem_rdata <= 8'hEE;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic put_inst(input logic [15:0] a, input logic [7:0] op, input logic [7:0] ln,
                            input logic [55:0] pl, input int n);
        mem[a] = op;
        mem[16'(a + 16'd1)] = ln;
        for (int i = 0; i < n; i++) mem[16'(a + 16'(i + 2))] = pl[i*8 +: 8];
    endtask

    // returns at the negedge of the first cycle of the fetch
    task automatic start_at(input logic [15:0] pc);
        rd_log.delete();
        start_pc = pc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.mem_rd_en, busy, bus.len_valid} !== 4'b0) begin
            $display("FAIL reset_flags: got %b expected 0000", {bus.out_valid, bus.mem_rd_en, busy, bus.len_valid}); n_fail++;
        end
        n_checks++;
        if ({bus.opcode, bus.inst_len, bus.inst_bytes, bus.inst_pc, bus.mem_addr} !== '0) begin
            $display("FAIL reset_fields: got op=%h len=%h bytes=%h pc=%h addr=%h expected all 0",
                     bus.opcode, bus.inst_len, bus.inst_bytes, bus.inst_pc, bus.mem_addr); n_fail++;
        end
        n_checks++;
        if (state_dbg !== S_IDLE) begin
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); n_fail++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        // redirect in IDLE is ignored
        redirect_pc = 16'h0040; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, bus.mem_rd_en, state_dbg} !== {1'b0, 1'b0, S_IDLE}) begin
            $display("FAIL idle_redirect: got busy=%b rd=%b st=%0d expected 0 0 0", busy, bus.mem_rd_en, state_dbg); n_fail++;
        end
    endtask

    task automatic test_add();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'h0010, `LLVM_OP_ADD, 8'd5, 56'h020103, 3);
        put_inst(16'h0015, `LLVM_OP_HALT, 8'd2, 56'h0, 0);
        start_at(16'h0010);
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 16'h0010}) begin
            $display("FAIL add_first_read: got rd=%b addr=%h expected 1 0010", bus.mem_rd_en, bus.mem_addr); n_fail++;
        end
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 6) begin
            $display("FAIL add_latency: got %0d cycles expected 6", cyc); n_fail++;
        end
        n_checks++;
        if ({bus.opcode, bus.inst_len, bus.len_valid, bus.inst_pc} !== {`LLVM_OP_ADD, 8'd5, 1'b1, 16'h0010}) begin
            $display("FAIL add_fields: got op=%h len=%h lv=%b pc=%h expected 01 05 1 0010",
                     bus.opcode, bus.inst_len, bus.len_valid, bus.inst_pc); n_fail++;
        end
        n_checks++;
        if (bus.inst_bytes !== 56'h020103) begin
            $display("FAIL add_bytes: got %h expected %h", bus.inst_bytes, 56'h020103); n_fail++;
        end
        ok = (rd_log.size() == 5 || rd_log.size() == 6);
        for (int i = 0; i < 5 && ok; i++) if (rd_log[i] !== 16'(16'h0010 + i)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL add_reads: got %0d reads (first %h) expected 0010..0014", rd_log.size(), rd_log[0]); n_fail++;
        end
        accept();
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.out_valid} !== {1'b1, 16'h0015, 1'b0}) begin
            $display("FAIL add_next_pc: got rd=%b addr=%h ov=%b expected 1 0015 0", bus.mem_rd_en, bus.mem_addr, bus.out_valid); n_fail++;
        end
        wait_valid(cyc);
        n_checks++;
        if ({bus.opcode, bus.inst_pc, cyc[7:0]} !== {`LLVM_OP_HALT, 16'h0015, 8'd3}) begin
            $display("FAIL halt_fields: got op=%h pc=%h cyc=%0d expected ff 0015 3", bus.opcode, bus.inst_pc, cyc); n_fail++;
        end
        accept();
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus.mem_rd_en !== 1'b0 || state_dbg !== S_WAIT || busy !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL halt_wait: got rd=%b st=%0d busy=%b expected 0 3 1", bus.mem_rd_en, state_dbg, busy); n_fail++;
        end
        // start outside IDLE is ignored
        start_pc = 16'h0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_rd_en, state_dbg} !== {1'b0, S_WAIT}) begin
            $display("FAIL wait_start_ignored: got rd=%b st=%0d expected 0 3", bus.mem_rd_en, state_dbg); n_fail++;
        end
    endtask

    task automatic test_stall();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'h0010, `LLVM_OP_ADD, 8'd5, 56'h020103, 3);
        start_at(16'h0010);
        wait_valid(cyc);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({bus.out_valid, bus.mem_rd_en, bus.opcode, bus.inst_len, bus.inst_bytes, bus.len_valid, bus.inst_pc} !==
                {1'b1, 1'b0, `LLVM_OP_ADD, 8'd5, 56'h020103, 1'b1, 16'h0010}) ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL stall_hold: got ov=%b rd=%b op=%h len=%h bytes=%h expected 1 0 01 05 020103",
                     bus.out_valid, bus.mem_rd_en, bus.opcode, bus.inst_len, bus.inst_bytes); n_fail++;
        end
        accept();
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 16'h0015}) begin
            $display("FAIL stall_resume: got rd=%b addr=%h expected 1 0015", bus.mem_rd_en, bus.mem_addr); n_fail++;
        end
    endtask

    task automatic test_branch();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'h0100, `LLVM_OP_BR, 8'd9, 56'h77665544332211, 7);
        start_at(16'h0100);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 10) begin
            $display("FAIL br_latency: got %0d cycles expected 10", cyc); n_fail++;
        end
        n_checks++;
        if ({bus.opcode, bus.inst_len, bus.len_valid, bus.inst_bytes} !== {`LLVM_OP_BR, 8'd9, 1'b1, 56'h77665544332211}) begin
            $display("FAIL br_fields: got op=%h len=%h lv=%b bytes=%h expected 20 09 1 77665544332211",
                     bus.opcode, bus.inst_len, bus.len_valid, bus.inst_bytes); n_fail++;
        end
        ok = (rd_log.size() == 9 || rd_log.size() == 10);
        for (int i = 0; i < 9 && ok; i++) if (rd_log[i] !== 16'(16'h0100 + i)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL br_reads: got %0d reads expected 0100..0108", rd_log.size()); n_fail++;
        end
        accept();
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus.mem_rd_en !== 1'b0 || state_dbg !== S_WAIT) ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL br_wait: got rd=%b st=%0d expected 0 3", bus.mem_rd_en, state_dbg); n_fail++;
        end
        redirect_pc = 16'h0040; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, state_dbg} !== {1'b1, 16'h0040, S_FETCH}) begin
            $display("FAIL br_redirect: got rd=%b addr=%h st=%0d expected 1 0040 1", bus.mem_rd_en, bus.mem_addr, state_dbg); n_fail++;
        end
    endtask

    task automatic test_illegal();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'h0200, `LLVM_OP_LOAD, 8'h0C, 56'hAABBCC, 3);
        put_inst(16'h0210, `LLVM_OP_LOAD, 8'h01, 56'hDDEE, 2);
        start_at(16'h0200);
        wait_valid(cyc);
        n_checks++;
        if ({bus.out_valid, bus.opcode, bus.inst_len, bus.len_valid, cyc[7:0]} !== {1'b1, `LLVM_OP_LOAD, 8'h0C, 1'b0, 8'd3}) begin
            $display("FAIL ill_fields: got ov=%b op=%h len=%h lv=%b cyc=%0d expected 1 10 0c 0 3",
                     bus.out_valid, bus.opcode, bus.inst_len, bus.len_valid, cyc); n_fail++;
        end
        n_checks++;
        if (bus.inst_bytes !== 56'h0) begin
            $display("FAIL ill_bytes: got %h expected 0", bus.inst_bytes); n_fail++;
        end
        n_checks++;
        if (rd_log.size() > 3) begin
            $display("FAIL ill_reads: got %0d reads expected at most 3", rd_log.size()); n_fail++;
        end
        accept();
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_rd_en !== 1'b0 || state_dbg !== S_WAIT) ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL ill_wait: got rd=%b st=%0d expected 0 3", bus.mem_rd_en, state_dbg); n_fail++;
        end
        // length below the minimum
        rd_log.delete();
        redirect_pc = 16'h0210; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(cyc);
        n_checks++;
        if ({bus.inst_len, bus.len_valid, bus.inst_bytes, bus.inst_pc} !== {8'h01, 1'b0, 56'h0, 16'h0210}) begin
            $display("FAIL short_fields: got len=%h lv=%b bytes=%h pc=%h expected 01 0 0 0210",
                     bus.inst_len, bus.len_valid, bus.inst_bytes, bus.inst_pc); n_fail++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'hFFFE, `LLVM_OP_LOAD, 8'd4, 56'hBBAA, 2);
        put_inst(16'h0002, `LLVM_OP_HALT, 8'd2, 56'h0, 0);
        start_at(16'hFFFE);
        wait_valid(cyc);
        n_checks++;
        if ({bus.opcode, bus.inst_bytes, bus.inst_pc, cyc[7:0]} !== {`LLVM_OP_LOAD, 56'hBBAA, 16'hFFFE, 8'd5}) begin
            $display("FAIL wrap_fields: got op=%h bytes=%h pc=%h cyc=%0d expected 10 bbaa fffe 5",
                     bus.opcode, bus.inst_bytes, bus.inst_pc, cyc); n_fail++;
        end
        ok = (rd_log.size() >= 4) && rd_log[0] === 16'hFFFE && rd_log[1] === 16'hFFFF &&
             rd_log[2] === 16'h0000 && rd_log[3] === 16'h0001;
        n_checks++;
        if (!ok) begin
            $display("FAIL wrap_reads: got %0d reads expected fffe ffff 0000 0001", rd_log.size()); n_fail++;
        end
        accept();
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 16'h0002}) begin
            $display("FAIL wrap_next_pc: got rd=%b addr=%h expected 1 0002", bus.mem_rd_en, bus.mem_addr); n_fail++;
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic ok;
        do_reset();
        put_inst(16'h0300, `LLVM_OP_BR, 8'd9, 56'h99887766554433, 7);
        put_inst(16'h0010, `LLVM_OP_ADD, 8'd5, 56'h020103, 3);
        start_at(16'h0300);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.mem_rd_en, busy, bus.len_valid, state_dbg, bus.opcode, bus.inst_len,
             bus.inst_bytes, bus.inst_pc, bus.mem_addr} !== '0) begin
            $display("FAIL async_reset: got ov=%b rd=%b busy=%b st=%0d op=%h len=%h bytes=%h expected all 0",
                     bus.out_valid, bus.mem_rd_en, busy, state_dbg, bus.opcode, bus.inst_len, bus.inst_bytes); n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL post_reset_quiet: got ov=%b rd=%b busy=%b expected 0 0 0", bus.out_valid, bus.mem_rd_en, busy); n_fail++;
        end
        // redirect mid-payload: the partial branch is never presented
        start_at(16'h0300);
        repeat (4) @(negedge clk);
        redirect_pc = 16'h0010; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.out_valid} !== {1'b1, 16'h0010, 1'b0}) begin
            $display("FAIL abort_redirect: got rd=%b addr=%h ov=%b expected 1 0010 0", bus.mem_rd_en, bus.mem_addr, bus.out_valid); n_fail++;
        end
        wait_valid(cyc);
        n_checks++;
        if ({bus.opcode, bus.inst_len, bus.inst_bytes, bus.inst_pc, cyc[7:0]} !==
            {`LLVM_OP_ADD, 8'd5, 56'h020103, 16'h0010, 8'd6}) begin
            $display("FAIL abort_first_out: got op=%h len=%h bytes=%h pc=%h cyc=%0d expected 01 05 020103 0010 6",
                     bus.opcode, bus.inst_len, bus.inst_bytes, bus.inst_pc, cyc); n_fail++;
        end
    endtask

    task automatic test_redirect_handshake();
        int cyc;
        do_reset();
        put_inst(16'h0010, `LLVM_OP_ADD, 8'd5, 56'h020103, 3);
        put_inst(16'h0100, `LLVM_OP_LOAD, 8'd3, 56'h5A, 1);
        start_at(16'h0010);
        wait_valid(cyc);
        // accept and redirect together: redirect target wins
        bus.out_ready = 1'b1; redirect_pc = 16'h0100; redirect_valid = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0; redirect_valid = 1'b0;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.out_valid} !== {1'b1, 16'h0100, 1'b0}) begin
            $display("FAIL hs_redirect: got rd=%b addr=%h ov=%b expected 1 0100 0", bus.mem_rd_en, bus.mem_addr, bus.out_valid); n_fail++;
        end
        wait_valid(cyc);
        n_checks++;
        if ({bus.opcode, bus.inst_bytes, bus.inst_pc, cyc[7:0]} !== {`LLVM_OP_LOAD, 56'h5A, 16'h0100, 8'd4}) begin
            $display("FAIL load3_fields: got op=%h bytes=%h pc=%h cyc=%0d expected 10 5a 0100 4",
                     bus.opcode, bus.inst_bytes, bus.inst_pc, cyc); n_fail++;
        end
        // redirect while stalled drops the pending output
        redirect_pc = 16'h0010; redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.mem_rd_en, bus.mem_addr} !== {1'b0, 1'b1, 16'h0010}) begin
            $display("FAIL stall_redirect_drop: got ov=%b rd=%b addr=%h expected 0 1 0010", bus.out_valid, bus.mem_rd_en, bus.mem_addr); n_fail++;
        end
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_stall();
        test_branch();
        test_illegal();
        test_wrap();
        test_abort();
        test_redirect_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
